// File: rtl/serial_tx_pkg.sv
// Shared types, constants and the round-robin helper for the UART TX arbiter.
package serial_tx_pkg;

    localparam int unsigned NUM_REQ              = 4;
    localparam int unsigned GID_W                = 2;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // First valid index scanning upward from ptr, wrapping; returns ptr if none valid.
    function automatic logic [GID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [GID_W-1:0]   ptr);
        logic [GID_W-1:0] idx;
        rr_pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + GID_W'(k);
            if (valid[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// Requester-side byte handshake bundle: valid/data/lock in, one-hot ready out.
interface serial_tx_arbiter_if;
    import serial_tx_pkg::*;

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_lock;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, output req_lock, input  req_ready);
    modport slave  (input  req_valid, input  req_data, input  req_lock, output req_ready);
endinterface

// File: rtl/serial_tx_frame.sv
// 8N1 framer: baud counter, shift register and START/DATA/STOP sequencing.
module serial_tx_frame
    import serial_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             bit_end_c;

    // State and datapath registers; reset forces the line idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state sequencing; line and busy are registered from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        bit_end_c = (cnt_q == CNT_LAST);

        if (state_q != IDLE) cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d = START;
                    shreg_d = byte_i;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            START: if (bit_end_c) state_d = DATA;
            DATA: begin
                if (bit_end_c) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    idx_d   = idx_q + 3'(1);
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: if (bit_end_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign busy_o = busy_q;
    assign tx_o   = tx_q;

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter with optional per-requester lock sharing one UART TX line.
module serial_tx_arbiter
    import serial_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             CLK,
    input  logic             RST_N,
    serial_tx_arbiter_if.slave req,
    output logic             serialOut,
    output logic             busy,
    output logic [GID_W-1:0] grant_id
);

    logic [GID_W-1:0] ptr_q, ptr_d;
    logic [GID_W-1:0] grant_q, grant_d;
    logic             lock_q, lock_d;
    logic [GID_W-1:0] winner_c;
    logic             accept_c;
    logic [7:0]       byte_c;

    // Pointer, lock flag and last grant.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q   <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            lock_q  <= lock_d;
        end
    end

    // Winner selection and combinational one-hot ready while the framer is idle.
    always_comb begin
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        lock_d        = lock_q;
        req.req_ready = '0;

        winner_c = rr_pick(req.req_valid, ptr_q);
        if (lock_q && req.req_valid[grant_q]) winner_c = grant_q;

        accept_c = !busy && (|req.req_valid);
        byte_c   = req.req_data[{winner_c, 3'b000} +: 8];

        if (accept_c) begin
            req.req_ready[winner_c] = 1'b1;
            grant_d = winner_c;
            lock_d  = req.req_lock[winner_c];
            ptr_d   = winner_c + GID_W'(1);
        end
    end

    serial_tx_frame #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_frame (
        .clk    (CLK),
        .rst_n  (RST_N),
        .load_i (accept_c),
        .byte_i (byte_c),
        .busy_o (busy),
        .tx_o   (serialOut)
    );

    assign grant_id = grant_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: reference model, vector table, corner sequences, random traffic.
module tb_serial_tx_arbiter;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic       serial_out;
    logic       busy;
    logic [1:0] grant_id;

    serial_tx_arbiter_if bus();

    serial_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .req       (bus),
        .serialOut (serial_out),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: m_t is cycles into the current frame, -1 when idle.
    int         m_t, m_ptr, m_grant;
    bit         m_lock, m_acc;
    logic [7:0] m_byte;

    logic       s_tx, s_busy, s_acc;
    logic [3:0] s_ready;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] lock;
        logic [7:0] data;
        int         exp_grant;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = -1; m_ptr = 0; m_grant = 0; m_lock = 0; m_byte = '0;
    endtask

    function automatic int pick(input logic [3:0] v);
        if (m_lock && v[m_grant]) return m_grant;
        for (int o = 0; o < 4; o++)
            if (v[(m_ptr + o) % 4]) return (m_ptr + o) % 4;
        return -1;
    endfunction

    // Frame bit k: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic fbit(input logic [7:0] b, input int t);
        int k;
        k = t / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // One clock: compare outputs at negedge against the model, then advance the model.
    task automatic step();
        logic [3:0] exp_ready;
        logic       exp_tx;
        int         w;
        @(negedge clk);
        w         = pick(bus.req_valid);
        m_acc     = (m_t < 0) && (w >= 0);
        exp_ready = m_acc ? 4'(1 << w) : 4'b0000;
        exp_tx    = (m_t < 0) ? 1'b1 : fbit(m_byte, m_t);
        chk("ready",     int'(bus.req_ready), int'(exp_ready));
        chk("busy",      int'(busy),          (m_t >= 0) ? 1 : 0);
        chk("serialOut", int'(serial_out),    int'(exp_tx));
        chk("grant_id",  int'(grant_id),      m_grant);
        s_tx    = serial_out;
        s_busy  = busy;
        s_ready = bus.req_ready;
        s_acc   = |(bus.req_ready & bus.req_valid);
        @(posedge clk);
        if (m_acc) begin
            m_byte  = bus.req_data[8*w +: 8];
            m_grant = w;
            m_lock  = bus.req_lock[w];
            m_ptr   = (w + 1) % 4;
            m_t     = 0;
        end else if (m_t >= 0) begin
            m_t++;
            if (m_t == 10 * CPB) m_t = -1;
        end
        #1;
    endtask

    task automatic set_lanes(input logic [7:0] d);
        bus.req_data = {d + 8'h33, d + 8'h22, d + 8'h11, d};
    endtask

    initial begin
        logic [9:0] a5_bits;
        int         n;

        a5_bits = 10'b1101001010;
        tbl[0]  = '{4'b1111, 4'b0000, 8'h3C, 1};
        tbl[1]  = '{4'b1111, 4'b0000, 8'h51, 2};
        tbl[2]  = '{4'b1111, 4'b0000, 8'hC7, 3};
        tbl[3]  = '{4'b1111, 4'b0000, 8'h08, 0};
        tbl[4]  = '{4'b0110, 4'b0010, 8'hE1, 1};
        tbl[5]  = '{4'b0110, 4'b0010, 8'h7E, 1};
        tbl[6]  = '{4'b0110, 4'b0000, 8'h99, 1};
        tbl[7]  = '{4'b0110, 4'b0000, 8'h24, 2};
        tbl[8]  = '{4'b0010, 4'b0010, 8'hF0, 1};
        tbl[9]  = '{4'b1000, 4'b0000, 8'h6B, 3};
        tbl[10] = '{4'b0101, 4'b0000, 8'h13, 0};
        tbl[11] = '{4'b0101, 4'b0000, 8'hAA, 2};
        tbl[12] = '{4'b0101, 4'b0000, 8'h5D, 0};

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_data  = '0;
        model_reset();

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_serialOut", int'(serial_out),    1);
        chk("rst_busy",      int'(busy),          0);
        chk("rst_ready",     int'(bus.req_ready), 0);
        chk("rst_grant",     int'(grant_id),      0);
        rst_n = 1'b1;
        repeat (20) step();

        // Single byte 0xA5 from requester 0: exact line pattern.
        set_lanes(8'hA5);
        bus.req_valid = 4'b0001;
        step();
        chk("a5_ready", int'(s_ready), 1);
        bus.req_valid = '0;
        for (int i = 0; i < 10 * CPB; i++) begin
            step();
            chk("a5_line", int'(s_tx), int'(a5_bits[i / CPB]));
            chk("a5_busy", int'(s_busy), 1);
        end
        step();
        chk("a5_idle_busy", int'(s_busy), 0);

        // Table: round-robin, lock hold/release, lock holder dropping valid.
        for (int r = 0; r < 13; r++) begin
            bus.req_valid = tbl[r].valid;
            bus.req_lock  = tbl[r].lock;
            set_lanes(tbl[r].data);
            n = 0;
            do begin
                step();
                n++;
            end while (!s_acc && n < 100);
            chk("tbl_accept", int'(s_acc), 1);
            chk("tbl_grant", int'(s_ready), 1 << tbl[r].exp_grant);
            if (r > 0) chk("tbl_period", n, 10 * CPB + 1);
        end
        bus.req_valid = '0;
        bus.req_lock  = '0;
        repeat (10 * CPB + 4) step();

        // Async reset in the middle of DATA.
        bus.req_valid = 4'b1000;
        bus.req_data  = {8'h92, 24'h0};
        n = 0;
        do begin
            step();
            n++;
        end while (!s_acc && n < 100);
        chk("mid_accept", int'(s_acc), 1);
        bus.req_valid = '0;
        repeat (CPB + 10) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_serialOut", int'(serial_out), 1);
        chk("async_busy",      int'(busy),       0);
        chk("async_grant",     int'(grant_id),   0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req_valid = 4'b0100;
        set_lanes(8'h3B);
        n = 0;
        do begin
            step();
            n++;
        end while (!s_acc && n < 100);
        chk("post_rst_ready", int'(s_ready), 4'b0100);
        bus.req_valid = '0;
        step();
        chk("post_rst_grant", int'(grant_id), 2);
        repeat (10 * CPB + 2) step();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.req_valid = 4'($urandom_range(0, 15));
                bus.req_lock  = 4'($urandom_range(0, 15));
                bus.req_data  = $urandom;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
